// File: rtl/vga_line_fetcher.sv
// Double-buffered scan-line fetcher: fills one line buffer from memory while
// the other is read out pixel by pixel for the VGA signal generator.
//
// Memory handshake: mem_req_o is high for the whole fill and mem_addr_o shows
// the word wanted this cycle. A beat transfers in any cycle where mem_req_o and
// mem_ack_i are both high; mem_data_i is taken in that cycle. Acks seen while
// mem_req_o is low are ignored. One beat per clock is allowed.
module vga_line_fetcher #(
  parameter int LINE_WORDS = 320,
  parameter int ADDR_W     = 18
) (
  input  logic              pix_clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic [ADDR_W-1:0] frame_base_i,
  input  logic              next_frame_i,
  input  logic              next_line_i,
  input  logic              next_pixel_i,
  output logic [15:0]       color_data_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_data_i,
  output logic              late_o,
  output logic              underrun_o,
  output logic              fsm_state     // debug: 1 while fetching
);

  localparam int WIDX_W = $clog2(LINE_WORDS);
  localparam int PIX_N  = 2 * LINE_WORDS;
  localparam int PIX_W  = $clog2(PIX_N);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] line_addr;
  logic [WIDX_W-1:0] word_idx;
  logic              fill_sel;
  logic              read_sel;
  logic [PIX_W-1:0]  pix_idx;

  logic [31:0] buf0 [LINE_WORDS];
  logic [31:0] buf1 [LINE_WORDS];

  // next_frame_i wins over next_line_i; both are dropped while disabled.
  logic trig_frame, trig_line, trig, beat, last_beat;
  assign trig_frame = enable_i & next_frame_i;
  assign trig_line  = enable_i & next_line_i & ~next_frame_i;
  assign trig       = trig_frame | trig_line;
  assign beat       = (state_q == FETCH) & mem_ack_i;
  assign last_beat  = beat & (word_idx == WIDX_W'(LINE_WORDS - 1));

  assign mem_req_o  = (state_q == FETCH);
  assign mem_addr_o = (state_q == FETCH) ? (line_addr + ADDR_W'(word_idx)) : '0;
  assign fsm_state  = (state_q == FETCH);

  // Read side: the first pixel of a line switches to the most recently started fill.
  logic              rd_sel_eff;
  logic [WIDX_W-1:0] rd_word;
  logic [31:0]       rd_data;
  logic              rd_ahead;
  assign rd_sel_eff = (pix_idx == '0) ? fill_sel : read_sel;
  assign rd_word    = pix_idx[PIX_W-1:1];
  assign rd_data    = rd_sel_eff ? buf1[rd_word] : buf0[rd_word];
  assign rd_ahead   = (state_q == FETCH) & (rd_sel_eff == fill_sel) & (rd_word >= word_idx);

  // State register; reset drops mem_req_o immediately.
  always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state: disable aborts, a trigger (re)starts, the last beat finishes.
  always_comb begin
    state_d = state_q;
    if (!enable_i)      state_d = IDLE;
    else if (trig)      state_d = FETCH;
    else if (last_beat) state_d = IDLE;
  end

  // Fill bookkeeping: line address, write buffer select, word index, late flag.
  always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      line_addr <= '0;
      word_idx  <= '0;
      fill_sel  <= 1'b0;
      late_o    <= 1'b0;
    end else if (enable_i) begin
      if (trig_frame) begin
        line_addr <= frame_base_i;
        fill_sel  <= 1'b0;
        word_idx  <= '0;
      end else if (trig_line) begin
        line_addr <= line_addr + ADDR_W'(LINE_WORDS);
        fill_sel  <= ~fill_sel;
        word_idx  <= '0;
      end else if (beat) begin
        word_idx  <= last_beat ? '0 : word_idx + WIDX_W'(1);
      end
      if (trig && (state_q == FETCH)) late_o <= 1'b1;
    end
  end

  // Line buffer write; a beat coinciding with a restart still lands in the old slot.
  always_ff @(posedge pix_clk_i) begin
    if (beat) begin
      if (fill_sel) buf1[word_idx] <= mem_data_i;
      else          buf0[word_idx] <= mem_data_i;
    end
  end

  // Pixel readout: one pixel per pulse, registered, with underrun detection.
  always_ff @(posedge pix_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      color_data_o <= '0;
      pix_idx      <= '0;
      read_sel     <= 1'b0;
      underrun_o   <= 1'b0;
    end else if (!enable_i) begin
      color_data_o <= '0;
    end else begin
      if (next_pixel_i) begin
        color_data_o <= pix_idx[0] ? rd_data[31:16] : rd_data[15:0];
        if (pix_idx == '0) read_sel <= fill_sel;
        if (rd_ahead) underrun_o <= 1'b1;
      end
      if (trig_frame)
        pix_idx <= '0;
      else if (next_pixel_i)
        pix_idx <= (pix_idx == PIX_W'(PIX_N - 1)) ? '0 : pix_idx + PIX_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Directed bench for vga_line_fetcher: fill table, pixel readout scoreboard,
// and hand-written sequences for late restart, underrun, disable and reset.
`timescale 1ns/1ps
module tb_vga_line_fetcher;

  localparam int LW = 320;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [AW-1:0] frame_base = '0;
  logic          next_frame = 1'b0;
  logic          next_line = 1'b0;
  logic          next_pix = 1'b0;
  logic [15:0]   color;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_data;
  logic          late;
  logic          underrun;
  logic          fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [AW-1:0] beat_q[$];
  logic [15:0]   exp_q[$];

  logic        ack_on = 1'b1;
  logic        ack_every4 = 1'b0;
  int unsigned ack_cnt = 0;

  vga_line_fetcher #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .pix_clk_i    (clk),
    .reset_n_i    (rst_n),
    .enable_i     (enable),
    .frame_base_i (frame_base),
    .next_frame_i (next_frame),
    .next_line_i  (next_line),
    .next_pixel_i (next_pix),
    .color_data_o (color),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_data),
    .late_o       (late),
    .underrun_o   (underrun),
    .fsm_state    (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Memory content is a fixed function of the word address.
  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    logic [15:0] h;
    h = a[15:0] ^ {a[17:16], 14'h0};
    return {~h, h};
  endfunction

  assign mem_data = data_of(mem_addr);

  // Memory ack generator: every cycle or every 4th cycle.
  always @(posedge clk) begin
    #2;
    ack_cnt++;
    mem_ack = ack_on && (!ack_every4 || (ack_cnt % 4 == 0));
  end

  // Beat monitor: logs the address of each beat the DUT will accept at the next edge.
  always @(negedge clk) begin
    if (mem_req && mem_ack) beat_q.push_back(mem_addr);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_fill_done(input string name);
    for (int c = 0; c < 3000 && mem_req; c++) step();
    check({name, "_done"}, {31'd0, mem_req}, 32'd0);
  endtask

  task automatic check_fill(input string name, input logic [AW-1:0] first, input logic [AW-1:0] last);
    int bad;
    bad = 0;
    check({name, "_beats"}, beat_q.size(), LW);
    if (beat_q.size() > 0) begin
      check({name, "_first"}, beat_q[0], first);
      check({name, "_last"}, beat_q[beat_q.size()-1], last);
    end
    foreach (beat_q[i]) if (beat_q[i] !== first + AW'(i)) bad++;
    check({name, "_seq"}, bad, 0);
    check({name, "_late"}, {31'd0, late}, 32'd0);
  endtask

  task automatic read_line(input string name, input logic [AW-1:0] first);
    logic [31:0] w;
    logic [15:0] e;
    logic [15:0] last_e;
    last_e = '0;
    next_pix = 1'b1;
    for (int i = 0; i < 2 * LW; i++) begin
      w = data_of(first + AW'(i / 2));
      exp_q.push_back(i[0] ? w[31:16] : w[15:0]);
      step();
      e = exp_q.pop_front();
      last_e = e;
      check({name, "_pix"}, {16'd0, color}, {16'd0, e});
    end
    next_pix = 1'b0;
    repeat (3) step();
    check({name, "_hold"}, {16'd0, color}, {16'd0, last_e});
  endtask

  typedef struct packed {
    logic          is_frame;
    logic [AW-1:0] base;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } fill_vec_t;

  fill_vec_t vecs [5];

  initial begin
    vecs[0] = '{1'b1, 18'h01000, 18'h01000, 18'h0113F};
    vecs[1] = '{1'b0, 18'h00000, 18'h01140, 18'h0127F};
    vecs[2] = '{1'b0, 18'h00000, 18'h01280, 18'h013BF};
    vecs[3] = '{1'b1, 18'h3FF00, 18'h3FF00, 18'h0003F};
    vecs[4] = '{1'b0, 18'h00000, 18'h00040, 18'h0017F};

    // Reset state
    step();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_color", {16'd0, color}, 32'd0);
    check("rst_late", {31'd0, late}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_state", {31'd0, fsm_state}, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_req", {31'd0, mem_req}, 32'd0);

    // Table of fills, each followed by a full line readout
    for (int v = 0; v < 5; v++) begin
      beat_q.delete();
      frame_base = vecs[v].base;
      if (vecs[v].is_frame) next_frame = 1'b1;
      else                  next_line  = 1'b1;
      step();
      next_frame = 1'b0;
      next_line  = 1'b0;
      check("fill_req", {31'd0, mem_req}, 32'd1);
      check("fill_state", {31'd0, fsm_state}, 32'd1);
      wait_fill_done("fill");
      check_fill("fill", vecs[v].exp_first, vecs[v].exp_last);
      read_line("line", vecs[v].exp_first);
    end
    check("table_underrun", {31'd0, underrun}, 32'd0);

    // Disable mid-fill: abort without late, output blanked, triggers ignored
    beat_q.delete();
    frame_base = 18'h04000;
    next_frame = 1'b1;
    step();
    next_frame = 1'b0;
    repeat (5) step();
    check("en_fetching", {31'd0, mem_req}, 32'd1);
    enable = 1'b0;
    step();
    check("en_abort_req", {31'd0, mem_req}, 32'd0);
    check("en_color_zero", {16'd0, color}, 32'd0);
    check("en_no_late", {31'd0, late}, 32'd0);
    next_line = 1'b1;
    step();
    next_line = 1'b0;
    step();
    check("en_trig_ignored", {31'd0, mem_req}, 32'd0);
    enable = 1'b1;
    step();

    // Late restart: next_line at beat 100 of a frame fill
    beat_q.delete();
    frame_base = 18'h02000;
    next_frame = 1'b1;
    step();
    next_frame = 1'b0;
    for (int c = 0; c < 1000 && beat_q.size() < 100; c++) step();
    check("late_pre", {31'd0, late}, 32'd0);
    next_line = 1'b1;
    step();
    next_line = 1'b0;
    wait_fill_done("late");
    check("late_set", {31'd0, late}, 32'd1);
    check("late_beats", beat_q.size(), 100 + LW);
    if (beat_q.size() > 100) begin
      check("late_before", beat_q[99], 18'h02063);
      check("late_restart", beat_q[100], 18'h02140);
      check("late_last", beat_q[beat_q.size()-1], 18'h0227F);
    end
    read_line("late_line", 18'h02140);

    // Underrun: slow memory, pixels every cycle from fill start
    check("ur_pre", {31'd0, underrun}, 32'd0);
    beat_q.delete();
    ack_every4 = 1'b1;
    frame_base = 18'h03000;
    next_frame = 1'b1;
    next_pix   = 1'b1;
    step();
    next_frame = 1'b0;
    repeat (20) step();
    next_pix = 1'b0;
    check("ur_set", {31'd0, underrun}, 32'd1);
    wait_fill_done("ur");
    check("ur_beats", beat_q.size(), LW);
    ack_every4 = 1'b0;

    // Reset during a fill: immediate outputs, no activity until a trigger
    beat_q.delete();
    frame_base = 18'h05000;
    next_frame = 1'b1;
    step();
    next_frame = 1'b0;
    repeat (10) step();
    check("rf_fetching", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rf_req", {31'd0, mem_req}, 32'd0);
    check("rf_addr", mem_addr, 32'd0);
    check("rf_color", {16'd0, color}, 32'd0);
    check("rf_late", {31'd0, late}, 32'd0);
    check("rf_underrun", {31'd0, underrun}, 32'd0);
    check("rf_state", {31'd0, fsm_state}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    beat_q.delete();
    repeat (10) step();
    check("rf_no_beats", beat_q.size(), 0);
    check("rf_idle", {31'd0, mem_req}, 32'd0);
    frame_base = 18'h05000;
    next_frame = 1'b1;
    step();
    next_frame = 1'b0;
    wait_fill_done("rf_fill");
    check_fill("rf_fill", 18'h05000, 18'h0513F);
    read_line("rf_line", 18'h05000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
